// File: rtl/gate_pkg.sv
// -----------------------------------------------------------------------------
// gate_pkg
// Shared constants for the gate bank.
//   OP_AND / OP_NAND / OP_NOR : op_sel encodings for the registered result mux.
//                               The fourth code (2'd3) is reserved and selects
//                               all zeros.
//   DEFAULT_WIDTH             : default operand/result width for every gate
//                               module and the bank top.
// -----------------------------------------------------------------------------
package gate_pkg;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_NAND = 2'd1;
    localparam logic [1:0] OP_NOR  = 2'd2;

    localparam int DEFAULT_WIDTH = 1;

endpackage : gate_pkg

// File: rtl/and_gate.sv
// -----------------------------------------------------------------------------
// and_gate
// Bitwise two-input AND, purely combinational.
//   a, b : operands (WIDTH bits)
//   y    : a & b, evaluated independently per bit
// -----------------------------------------------------------------------------
module and_gate #(
    parameter int WIDTH = gate_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = a[gi] & b[gi];
    end

endmodule : and_gate

// File: rtl/nand_gate.sv
// -----------------------------------------------------------------------------
// nand_gate
// Bitwise two-input NAND, purely combinational.
//   a, b : operands (WIDTH bits)
//   y    : ~(a & b), evaluated independently per bit
// -----------------------------------------------------------------------------
module nand_gate #(
    parameter int WIDTH = gate_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = ~(a[gi] & b[gi]);
    end

endmodule : nand_gate

// File: rtl/nor_gate.sv
// -----------------------------------------------------------------------------
// nor_gate
// Bitwise two-input NOR, purely combinational.
//   a, b : operands (WIDTH bits)
//   y    : ~(a | b), evaluated independently per bit
// -----------------------------------------------------------------------------
module nor_gate #(
    parameter int WIDTH = gate_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = ~(a[gi] | b[gi]);
    end

endmodule : nor_gate

// File: rtl/and_nand_nor_bank.sv
// -----------------------------------------------------------------------------
// and_nand_nor_bank
// Bitwise AND/NAND/NOR bank with combinational outputs and a one-stage,
// valid-qualified registered copy plus a selectable registered result.
//   clk       : rising-edge clock for all registers
//   rst_n     : asynchronous active-low reset (clears q_* and out_valid)
//   a, b      : operands (WIDTH bits)
//   in_valid  : a, b, op_sel are valid this cycle; gates the capture
//   op_sel    : registered result select (AND, NAND, NOR, reserved -> zeros)
//   y_and     : combinational a & b
//   y_nand    : combinational ~(a & b)
//   y_nor     : combinational ~(a | b)
//   q_and, q_nand, q_nor : registered gate results, loaded when in_valid
//   q_sel     : registered op_sel-selected result, loaded when in_valid
//   out_valid : registered in_valid (q_* were loaded on the last edge)
// -----------------------------------------------------------------------------
module and_nand_nor_bank
    import gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic [1:0]       op_sel,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_nand,
    output logic [WIDTH-1:0] y_nor,
    output logic [WIDTH-1:0] q_and,
    output logic [WIDTH-1:0] q_nand,
    output logic [WIDTH-1:0] q_nor,
    output logic [WIDTH-1:0] q_sel,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_next;

    and_gate #(.WIDTH(WIDTH)) u_and (
        .a (a),
        .b (b),
        .y (y_and)
    );

    nand_gate #(.WIDTH(WIDTH)) u_nand (
        .a (a),
        .b (b),
        .y (y_nand)
    );

    nor_gate #(.WIDTH(WIDTH)) u_nor (
        .a (a),
        .b (b),
        .y (y_nor)
    );

    // Result select; the reserved code falls through to all zeros.
    always_comb begin
        sel_next = '0;
        case (op_sel)
            OP_AND:  sel_next = y_and;
            OP_NAND: sel_next = y_nand;
            OP_NOR:  sel_next = y_nor;
            default: sel_next = '0;
        endcase
    end

    // Data registers only load on valid cycles; out_valid follows in_valid
    // every edge so it drops as soon as a bubble arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_and     <= '0;
            q_nand    <= '0;
            q_nor     <= '0;
            q_sel     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                q_and  <= y_and;
                q_nand <= y_nand;
                q_nor  <= y_nor;
                q_sel  <= sel_next;
            end
        end
    end

endmodule : and_nand_nor_bank

// File: tb/tb_and_nand_nor_bank.sv
// -----------------------------------------------------------------------------
// tb_and_nand_nor_bank
// Directed bench for and_nand_nor_bank at WIDTH = 1, 8 and 16.
// -----------------------------------------------------------------------------
module tb_and_nand_nor_bank;

    logic clk;
    logic rst_n;

    int tests_run    = 0;
    int tests_failed = 0;

    // WIDTH = 1 instance (combinational truth table)
    logic [0:0] a1, b1;
    logic       v1;
    logic [1:0] op1;
    logic [0:0] y_and1, y_nand1, y_nor1, q_and1, q_nand1, q_nor1, q_sel1;
    logic       ov1;

    // WIDTH = 8 instance (registered path)
    logic [7:0] a8, b8;
    logic       v8;
    logic [1:0] op8;
    logic [7:0] y_and8, y_nand8, y_nor8, q_and8, q_nand8, q_nor8, q_sel8;
    logic       ov8;

    // WIDTH = 16 instance (random invariants)
    logic [15:0] a16, b16;
    logic        v16;
    logic [1:0]  op16;
    logic [15:0] y_and16, y_nand16, y_nor16, q_and16, q_nand16, q_nor16, q_sel16;
    logic        ov16;

    and_nand_nor_bank #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .op_sel(op1),
        .y_and(y_and1), .y_nand(y_nand1), .y_nor(y_nor1),
        .q_and(q_and1), .q_nand(q_nand1), .q_nor(q_nor1), .q_sel(q_sel1),
        .out_valid(ov1)
    );

    and_nand_nor_bank #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8), .op_sel(op8),
        .y_and(y_and8), .y_nand(y_nand8), .y_nor(y_nor8),
        .q_and(q_and8), .q_nand(q_nand8), .q_nor(q_nor8), .q_sel(q_sel8),
        .out_valid(ov8)
    );

    and_nand_nor_bank #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(v16), .op_sel(op16),
        .y_and(y_and16), .y_nand(y_nand16), .y_nor(y_nor16),
        .q_and(q_and16), .q_nand(q_nand16), .q_nor(q_nor16), .q_sel(q_sel16),
        .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [2:0]  tt_exp [4];
        logic [7:0]  sweep_exp [4];
        logic [7:0]  hold_and, hold_nand, hold_nor, hold_sel;
        logic [15:0] ra, rb;

        // (and,nand,nor) for ab = 00, 01, 10, 11
        tt_exp[0] = 3'b011;
        tt_exp[1] = 3'b010;
        tt_exp[2] = 3'b010;
        tt_exp[3] = 3'b100;
        sweep_exp[0] = 8'h0A;
        sweep_exp[1] = 8'hF5;
        sweep_exp[2] = 8'h50;
        sweep_exp[3] = 8'h00;

        rst_n = 1'b0;
        a1 = '0; b1 = '0; v1 = 1'b0; op1 = 2'd0;
        a8 = '0; b8 = '0; v8 = 1'b0; op8 = 2'd0;
        a16 = '0; b16 = '0; v16 = 1'b0; op16 = 2'd0;

        // Reset state
        #3;
        check("rst_q_and",  {8'h0, q_and8},  16'h0000);
        check("rst_q_nand", {8'h0, q_nand8}, 16'h0000);
        check("rst_q_nor",  {8'h0, q_nor8},  16'h0000);
        check("rst_q_sel",  {8'h0, q_sel8},  16'h0000);
        check("rst_valid",  {15'h0, ov8},    16'h0000);

        // Combinational truth table at WIDTH = 1, independent of reset/clk
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #100;
            $display("[TB] tt a=%b b=%b -> and=%b nand=%b nor=%b", a1, b1, y_and1, y_nand1, y_nor1);
            check("tt_and",  {15'h0, y_and1},  {15'h0, tt_exp[i][2]});
            check("tt_nand", {15'h0, y_nand1}, {15'h0, tt_exp[i][1]});
            check("tt_nor",  {15'h0, y_nor1},  {15'h0, tt_exp[i][0]});
        end

        // Release reset between edges; nothing captured while in_valid=0
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rel_valid", {15'h0, ov8}, 16'h0000);

        // Registered path
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'hCC; op8 = 2'd1; v8 = 1'b1;
        @(posedge clk); #1;
        $display("[TB] cap a=F0 b=CC op=1 -> q_and=%h q_nand=%h q_nor=%h q_sel=%h ov=%b",
                 q_and8, q_nand8, q_nor8, q_sel8, ov8);
        check("cap_q_and",  {8'h0, q_and8},  16'h00C0);
        check("cap_q_nand", {8'h0, q_nand8}, 16'h003F);
        check("cap_q_nor",  {8'h0, q_nor8},  16'h0003);
        check("cap_q_sel",  {8'h0, q_sel8},  16'h003F);
        check("cap_valid",  {15'h0, ov8},    16'h0001);
        hold_and = 8'hC0; hold_nand = 8'h3F; hold_nor = 8'h03; hold_sel = 8'h3F;

        // Hold: in_valid low while operands change
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v8 = 1'b0;
            a8 = 8'h11 * (i + 1);
            b8 = 8'h5A ^ 8'(i);
            op8 = 2'(i);
            @(posedge clk); #1;
            $display("[TB] hold %0d a=%h b=%h -> q_and=%h q_sel=%h ov=%b", i, a8, b8, q_and8, q_sel8, ov8);
            check("hold_q_and",  {8'h0, q_and8},  {8'h0, hold_and});
            check("hold_q_nand", {8'h0, q_nand8}, {8'h0, hold_nand});
            check("hold_q_nor",  {8'h0, q_nor8},  {8'h0, hold_nor});
            check("hold_q_sel",  {8'h0, q_sel8},  {8'h0, hold_sel});
            check("hold_valid",  {15'h0, ov8},    16'h0000);
        end

        // Select sweep, back-to-back valid
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = 8'hAA; b8 = 8'h0F; op8 = 2'(i); v8 = 1'b1;
            @(posedge clk); #1;
            $display("[TB] sweep op=%0d -> q_sel=%h ov=%b", i, q_sel8, ov8);
            check("sweep_q_sel", {8'h0, q_sel8}, {8'h0, sweep_exp[i]});
            check("sweep_valid", {15'h0, ov8},   16'h0001);
            check("sweep_q_and", {8'h0, q_and8}, 16'h000A);
            check("sweep_q_nor", {8'h0, q_nor8}, 16'h0050);
        end

        // Asynchronous reset mid-cycle while out_valid=1
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async rst -> q_and=%h q_nand=%h q_nor=%h q_sel=%h ov=%b y_and=%h",
                 q_and8, q_nand8, q_nor8, q_sel8, ov8, y_and8);
        check("arst_q_and",  {8'h0, q_and8},  16'h0000);
        check("arst_q_nand", {8'h0, q_nand8}, 16'h0000);
        check("arst_q_nor",  {8'h0, q_nor8},  16'h0000);
        check("arst_q_sel",  {8'h0, q_sel8},  16'h0000);
        check("arst_valid",  {15'h0, ov8},    16'h0000);
        check("arst_y_and",  {8'h0, y_and8},  16'h000A);
        check("arst_y_nand", {8'h0, y_nand8}, 16'h00F5);
        check("arst_y_nor",  {8'h0, y_nor8},  16'h0050);
        a8 = 8'hFF;
        #1;
        check("arst_track_and",  {8'h0, y_and8},  16'h000F);
        check("arst_track_nand", {8'h0, y_nand8}, 16'h00F0);
        check("arst_track_nor",  {8'h0, y_nor8},  16'h0000);
        @(posedge clk); #1;
        check("arst_hold_valid", {15'h0, ov8},   16'h0000);
        check("arst_hold_q_and", {8'h0, q_and8}, 16'h0000);

        // Release, then first valid edge captures
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h3C; b8 = 8'h66; op8 = 2'd2; v8 = 1'b1;
        @(posedge clk); #1;
        $display("[TB] post-reset cap -> q_and=%h q_sel=%h ov=%b", q_and8, q_sel8, ov8);
        check("rel_q_and", {8'h0, q_and8}, 16'h0024);
        check("rel_q_sel", {8'h0, q_sel8}, 16'h0081);
        check("rel_valid", {15'h0, ov8},   16'h0001);
        @(negedge clk);
        v8 = 1'b0;

        // Random invariants at WIDTH = 16
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            a16 = ra;
            b16 = rb;
            #1;
            check("inv_nand",    y_nand16, ~y_and16);
            check("inv_nor_and", y_nor16 & y_and16, 16'h0000);
            check("inv_and_val", y_and16, ra & rb);
            check("inv_nor_val", y_nor16, ~(ra | rb));
        end
        $display("[TB] invariant sweep: 1000 random pairs applied at WIDTH=16");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_and_nand_nor_bank
